ram_param: RTL

RAM_PARAM -- requirements
Module: ram_param

---
 rtl/ram_param_if.sv | 31 +++
 rtl/ram_param.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ram_param_if.sv
// Bus bundle for ram_param: user write port, user read port and status.
//
// Handshake: ready is a level, not a per-transfer acknowledge. A write
// (we) or read (re) is accepted on a rising edge only when ready was 1
// before that edge and init_req is 0 on that edge. Nothing is queued.
// Each accepted read returns rdata with rvalid=1 one cycle later.
// rvalid is a single-cycle qualifier with no back-pressure.
interface ram_param_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
);
   logic                  init_req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  re;
   logic [ADDR_WIDTH-1:0] raddr;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rvalid;
   logic                  ready;

   modport master (
      output init_req, we, waddr, wdata, re, raddr,
      input  rdata, rvalid, ready
   );

   modport slave (
      input  init_req, we, waddr, wdata, re, raddr,
      output rdata, rvalid, ready
   );
endinterface

// File: rtl/ram_param.sv
// Simple dual-port RAM (one write port, one registered read port).
// A self-clearing sweep writes INIT_VALUE to every word after reset or
// on request. User accesses are only accepted once the sweep is done.
module ram_param #(
   parameter int          DATA_WIDTH = 8,
   parameter int          ADDR_WIDTH = 3,
   parameter logic [63:0] INIT_VALUE = 64'd0,
   parameter bit          BYPASS     = 1'b1
) (
   input  logic        clk,
   input  logic        clear,
   ram_param_if.slave  bus,
   output logic        o_dbg_state   // 1 = RUN, 0 = INIT sweep
);

   localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [DATA_WIDTH-1:0] INIT_WORD = INIT_VALUE[DATA_WIDTH-1:0];
   localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [ADDR_WIDTH-1:0] w_ptr_nxt;
   logic                  r_ready;
   logic                  w_ready_nxt;
   logic                  r_rvalid;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_sweep_we;
   logic                  w_user_we;
   logic                  w_user_re;
   logic                  w_bypass_hit;

   // Next state, sweep pointer and gated user strobes. init_req wins over
   // we/re on the same edge. Sweep writes stay off while clear is high
   // because the array has no reset of its own.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_ready_nxt = r_ready;
      w_sweep_we  = 1'b0;
      w_user_we   = 1'b0;
      w_user_re   = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_sweep_we = ~clear;
            w_ptr_nxt  = r_ptr + PTR_ONE;
            if (r_ptr == PTR_LAST) begin
               w_state_nxt = ST_RUN;
               w_ready_nxt = 1'b1;
            end
         end
         ST_RUN: begin
            if (bus.init_req) begin
               w_state_nxt = ST_INIT;
               w_ready_nxt = 1'b0;
               w_ptr_nxt   = '0;
            end else begin
               w_user_we = bus.we;
               w_user_re = bus.re;
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
            w_ready_nxt = 1'b0;
            w_ptr_nxt   = '0;
         end
      endcase
   end

   // Same-address write and read on one edge: forward wdata in write-first mode.
   assign w_bypass_hit = BYPASS && w_user_we && (bus.waddr == bus.raddr);

   // FSM state, sweep pointer and the registered ready flag.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_state <= ST_INIT;
         r_ptr   <= '0;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_ready <= w_ready_nxt;
      end
   end

   // Storage array: sweep writes during INIT, user writes during RUN.
   always_ff @(posedge clk) begin
      if (w_sweep_we) begin
         r_mem[r_ptr] <= INIT_WORD;
      end else if (w_user_we) begin
         r_mem[bus.waddr] <= bus.wdata;
      end
   end

   // Registered read port. rdata holds its value when no read is accepted.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= w_user_re;
         if (w_user_re) begin
            r_rdata <= w_bypass_hit ? bus.wdata : r_mem[bus.raddr];
         end
      end
   end

   assign bus.rdata   = r_rdata;
   assign bus.rvalid  = r_rvalid;
   assign bus.ready   = r_ready;
   assign o_dbg_state = (r_state == ST_RUN);

endmodule
